// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, blanking, coordinates, line/frame strobes
// and a completed-frame counter, advanced by a pixel clock-enable in the system clock domain.
module vga_timing_gen #(
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 8,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 35,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0,
    parameter int CW     = 12,
    parameter int FW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_cnt
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_DISP_C     = CW'(H_DISP);
    localparam logic [CW-1:0] V_DISP_C     = CW'(V_DISP);
    localparam logic [CW-1:0] H_SYNC_FIRST = CW'(H_DISP + H_FP);
    localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] V_SYNC_FIRST = CW'(V_DISP + V_FP);
    localparam logic [CW-1:0] V_SYNC_LAST  = CW'(V_DISP + V_FP + V_SYNC - 1);

    logic          started;
    logic [CW-1:0] next_x;
    logic [CW-1:0] next_y;
    logic          frame_wrap;
    logic [CW-1:0] show_x;
    logic [CW-1:0] show_y;
    logic          show_line;
    logic          show_frame;
    logic          bump_cnt;

    always_comb begin
        next_x     = pixel_x + CW'(1);
        next_y     = pixel_y;
        frame_wrap = 1'b0;
        if (pixel_x == H_LAST) begin
            next_x = '0;
            if (pixel_y == V_LAST) begin
                next_y     = '0;
                frame_wrap = 1'b1;
            end else begin
                next_y = pixel_y + CW'(1);
            end
        end
    end

    // Pick the position the registers will present next; every output is decoded from it
    // so sync, blanking and coordinates can never drift apart.
    always_comb begin
        show_x     = pixel_x;
        show_y     = pixel_y;
        show_line  = 1'b0;
        show_frame = 1'b0;
        bump_cnt   = 1'b0;
        if (!started) begin
            show_x     = '0;
            show_y     = '0;
            show_line  = 1'b1;
            show_frame = 1'b1;
        end else if (pix_ce) begin
            show_x     = next_x;
            show_y     = next_y;
            show_line  = (next_x == '0);
            show_frame = frame_wrap;
            bump_cnt   = frame_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            started     <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            started     <= 1'b1;
            pixel_x     <= show_x;
            pixel_y     <= show_y;
            video_on    <= (show_x < H_DISP_C) && (show_y < V_DISP_C);
            hsync       <= ((show_x >= H_SYNC_FIRST) && (show_x <= H_SYNC_LAST)) ? H_POL : ~H_POL;
            vsync       <= ((show_y >= V_SYNC_FIRST) && (show_y <= V_SYNC_LAST)) ? V_POL : ~V_POL;
            line_start  <= show_line;
            frame_start <= show_frame;
            frame_cnt   <= frame_cnt + FW'(bump_cnt);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: three modes (default VGA, small active-low, tiny
// active-high) compared every cycle against an arithmetic model of the raster position.
module tb_vga_timing_gen;

    localparam int NUM_DUT = 3;
    localparam int PHASE0_END = 1300;
    localparam int PHASE1_END = 3900;
    localparam int PHASE2_END = 11900;
    localparam int PHASE3_END = 15000;

    int h_disp[NUM_DUT] = '{640, 20, 4};
    int h_fp[NUM_DUT]   = '{16, 3, 1};
    int h_sync[NUM_DUT] = '{96, 5, 2};
    int h_bp[NUM_DUT]   = '{48, 4, 1};
    int v_disp[NUM_DUT] = '{480, 12, 2};
    int v_fp[NUM_DUT]   = '{8, 2, 1};
    int v_sync[NUM_DUT] = '{2, 2, 1};
    int v_bp[NUM_DUT]   = '{35, 3, 1};
    int h_pol[NUM_DUT]  = '{0, 0, 1};
    int v_pol[NUM_DUT]  = '{0, 0, 1};
    int fw[NUM_DUT]     = '{8, 3, 2};

    logic clk;
    logic [NUM_DUT-1:0] rst;
    logic [NUM_DUT-1:0] ce;

    logic        hs0, vs0, von0, ls0, fs0;
    logic [11:0] px0, py0;
    logic [7:0]  fc0;
    logic        hs1, vs1, von1, ls1, fs1;
    logic [11:0] px1, py1;
    logic [2:0]  fc1;
    logic        hs2, vs2, von2, ls2, fs2;
    logic [11:0] px2, py2;
    logic [1:0]  fc2;

    vga_timing_gen dut_vga (
        .clk(clk), .rst(rst[0]), .pix_ce(ce[0]),
        .hsync(hs0), .vsync(vs0), .video_on(von0),
        .pixel_x(px0), .pixel_y(py0),
        .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .H_DISP(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_DISP(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b0), .V_POL(1'b0), .CW(12), .FW(3)
    ) dut_small (
        .clk(clk), .rst(rst[1]), .pix_ce(ce[1]),
        .hsync(hs1), .vsync(vs1), .video_on(von1),
        .pixel_x(px1), .pixel_y(py1),
        .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
    );

    vga_timing_gen #(
        .H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_DISP(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(12), .FW(2)
    ) dut_tiny (
        .clk(clk), .rst(rst[2]), .pix_ce(ce[2]),
        .hsync(hs2), .vsync(vs2), .video_on(von2),
        .pixel_x(px2), .pixel_y(py2),
        .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2)
    );

    int checks_done = 0;
    int checks_passed = 0;

    longint ticks[NUM_DUT];
    bit     live[NUM_DUT];
    int     rst_left[NUM_DUT];
    int exp_x[NUM_DUT], exp_y[NUM_DUT], exp_von[NUM_DUT], exp_hs[NUM_DUT], exp_vs[NUM_DUT];
    int exp_ls[NUM_DUT], exp_fs[NUM_DUT], exp_fc[NUM_DUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_done++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // The position is simply the number of pixel advances since reset, folded by the raster size.
    task automatic modelStep(input int i, input bit r, input bit c);
        bit     fresh;
        longint h_tot, v_tot;
        h_tot = h_disp[i] + h_fp[i] + h_sync[i] + h_bp[i];
        v_tot = v_disp[i] + v_fp[i] + v_sync[i] + v_bp[i];
        fresh = 1'b0;
        if (r) begin
            live[i]  = 1'b0;
            ticks[i] = 0;
        end else if (!live[i]) begin
            live[i]  = 1'b1;
            ticks[i] = 0;
            fresh    = 1'b1;
        end else if (c) begin
            ticks[i]++;
            fresh = 1'b1;
        end
        if (r) begin
            exp_x[i] = 0; exp_y[i] = 0; exp_von[i] = 0;
            exp_hs[i] = 1 - h_pol[i]; exp_vs[i] = 1 - v_pol[i];
            exp_ls[i] = 0; exp_fs[i] = 0; exp_fc[i] = 0;
        end else begin
            exp_x[i]   = int'(ticks[i] % h_tot);
            exp_y[i]   = int'((ticks[i] / h_tot) % v_tot);
            exp_fc[i]  = int'((ticks[i] / (h_tot * v_tot)) % (64'd1 << fw[i]));
            exp_von[i] = (exp_x[i] < h_disp[i] && exp_y[i] < v_disp[i]) ? 1 : 0;
            exp_hs[i]  = (exp_x[i] >= h_disp[i] + h_fp[i] && exp_x[i] < h_disp[i] + h_fp[i] + h_sync[i])
                         ? h_pol[i] : 1 - h_pol[i];
            exp_vs[i]  = (exp_y[i] >= v_disp[i] + v_fp[i] && exp_y[i] < v_disp[i] + v_fp[i] + v_sync[i])
                         ? v_pol[i] : 1 - v_pol[i];
            exp_ls[i]  = (fresh && exp_x[i] == 0) ? 1 : 0;
            exp_fs[i]  = (fresh && exp_x[i] == 0 && exp_y[i] == 0) ? 1 : 0;
        end
    endtask

    task automatic checkInstance(input int i, input logic h, input logic v, input logic vo,
                                 input logic [11:0] x, input logic [11:0] y,
                                 input logic l, input logic f, input logic [7:0] fc);
        checkOutput($sformatf("d%0d.pixel_x", i), 32'(x), exp_x[i]);
        checkOutput($sformatf("d%0d.pixel_y", i), 32'(y), exp_y[i]);
        checkOutput($sformatf("d%0d.video_on", i), 32'(vo), exp_von[i]);
        checkOutput($sformatf("d%0d.hsync", i), 32'(h), exp_hs[i]);
        checkOutput($sformatf("d%0d.vsync", i), 32'(v), exp_vs[i]);
        checkOutput($sformatf("d%0d.line_start", i), 32'(l), exp_ls[i]);
        checkOutput($sformatf("d%0d.frame_start", i), 32'(f), exp_fs[i]);
        checkOutput($sformatf("d%0d.frame_cnt", i), 32'(fc), exp_fc[i]);
    endtask

    // Phase 0: continuous enable; 1: enable one cycle in four; 2: random enable;
    // 3: random enable with occasional short resets landing mid-frame.
    task automatic applyStimulus(input int cyc);
        for (int i = 0; i < NUM_DUT; i++) begin
            bit r, c;
            r = 1'b0;
            c = 1'b1;
            if (cyc < 2) begin
                r = 1'b1;
            end else if (cyc < PHASE0_END) begin
                c = 1'b1;
            end else if (cyc < PHASE1_END) begin
                c = (cyc % 4 == 0);
            end else if (cyc < PHASE2_END) begin
                c = ($urandom_range(0, 3) != 0);
            end else begin
                c = ($urandom_range(0, 3) != 0);
                if (rst_left[i] == 0 && $urandom_range(0, 199) == 0) begin
                    rst_left[i] = $urandom_range(1, 3);
                end
                if (rst_left[i] > 0) begin
                    r = 1'b1;
                    rst_left[i]--;
                end
            end
            rst[i] = r;
            ce[i]  = c;
            modelStep(i, r, c);
        end
    endtask

    initial begin
        rst = '1;
        ce  = '0;
        for (int i = 0; i < NUM_DUT; i++) begin
            live[i] = 1'b0;
            ticks[i] = 0;
            rst_left[i] = 0;
        end
        applyStimulus(0);
        for (int cyc = 1; cyc < PHASE3_END; cyc++) begin
            @(negedge clk);
            checkInstance(0, hs0, vs0, von0, px0, py0, ls0, fs0, fc0);
            checkInstance(1, hs1, vs1, von1, px1, py1, ls1, fs1, 8'(fc1));
            checkInstance(2, hs2, vs2, von2, px2, py2, ls2, fs2, 8'(fc2));
            applyStimulus(cyc);
        end
        @(negedge clk);
        checkInstance(0, hs0, vs0, von0, px0, py0, ls0, fs0, fc0);
        checkInstance(1, hs1, vs1, von1, px1, py1, ls1, fs1, 8'(fc1));
        checkInstance(2, hs2, vs2, von2, px2, py2, ls2, fs2, 8'(fc2));
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_done);
        $finish;
    end

endmodule
